truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 119 +++++++++++
 tb/tb_truth_table_sweeper.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Steps a 3-bit vector through 0..7 into an external combinational function and
// captures its response into an 8-bit truth table. Optional checker: TT_CHECK_EN.
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       y_in,
`ifdef TT_CHECK_EN
  input  logic [7:0] expected,
  output logic       pass,
  output logic       fail,
`endif
  output logic [2:0] abc_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} stateT;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  stateT      stateQ, stateD;
  logic [2:0] indexQ, indexD;
  logic [3:0] cntQ, cntD;
  logic [7:0] tableQ, tableD;

`ifdef TT_CHECK_EN
  logic passQ, passD, failQ, failD;
  assign pass = passQ;
  assign fail = failQ;
`endif

  assign table_out = tableQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= StIdle;
      indexQ <= 3'd0;
      cntQ   <= 4'd0;
      tableQ <= 8'h00;
`ifdef TT_CHECK_EN
      passQ  <= 1'b0;
      failQ  <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      indexQ <= indexD;
      cntQ   <= cntD;
      tableQ <= tableD;
`ifdef TT_CHECK_EN
      passQ  <= passD;
      failQ  <= failD;
`endif
    end
  end

  always_comb begin
    stateD  = stateQ;
    indexD  = indexQ;
    cntD    = cntQ;
    tableD  = tableQ;
    abc_out = 3'd0;
    busy    = 1'b0;
    done    = 1'b0;
`ifdef TT_CHECK_EN
    passD   = passQ;
    failD   = failQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          stateD = StDrive;
          indexD = 3'd0;
          cntD   = 4'd0;
          tableD = 8'h00;
`ifdef TT_CHECK_EN
          passD  = 1'b0;
          failD  = 1'b0;
`endif
        end
      end
      StDrive: begin
        busy    = 1'b1;
        abc_out = indexQ;
        if (cntQ == SettleLast) begin
          stateD = StSample;
        end else begin
          cntD = cntQ + 4'd1;
        end
      end
      StSample: begin
        busy           = 1'b1;
        abc_out        = indexQ;
        tableD[indexQ] = y_in;
        if (indexQ == 3'd7) begin
          stateD = StDone;
`ifdef TT_CHECK_EN
          // Compare against the table including the bit captured this cycle.
          passD  = (tableD == expected);
          failD  = (tableD != expected);
`endif
        end else begin
          stateD = StDrive;
          indexD = indexQ + 3'd1;
          cntD   = 4'd0;
        end
      end
      StDone: begin
        done   = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (SETTLE=1 and SETTLE=3) driven in parallel,
// each answering with its own lookup-table function, checked against a timing model.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] tbl1, tbl3, exp1, exp3;
  logic       y1, y3, busy1, busy3, done1, done3, pass1, pass3, fail1, fail3;
  logic [2:0] abc1, abc3;
  logic [7:0] tab1, tab3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign y1 = tbl1[abc1];
  assign y3 = tbl3[abc3];

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .y_in      (y1),
`ifdef TT_CHECK_EN
    .expected  (exp1),
    .pass      (pass1),
    .fail      (fail1),
`endif
    .abc_out   (abc1),
    .busy      (busy1),
    .done      (done1),
    .table_out (tab1)
  );

  truth_table_sweeper #(.SETTLE(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .y_in      (y3),
`ifdef TT_CHECK_EN
    .expected  (exp3),
    .pass      (pass3),
    .fail      (fail3),
`endif
    .abc_out   (abc3),
    .busy      (busy3),
    .done      (done3),
    .table_out (tab3)
  );

`ifndef TT_CHECK_EN
  assign pass1 = 1'b0;
  assign pass3 = 1'b0;
  assign fail1 = 1'b0;
  assign fail3 = 1'b0;
`endif

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Expected outputs t cycles after start acceptance: each vector takes s+1 cycles,
  // bit i lands in the table once vector i has been sampled.
  task automatic checkDut(input string tag, input int t, input int s, input logic b,
                          input logic [2:0] a, input logic d, input logic [7:0] tab,
                          input logic [7:0] tbl, input logic p, input logic f,
                          input logic [7:0] ex);
    int         per, last;
    logic       eBusy;
    logic [2:0] eAbc;
    logic [7:0] eTab;
    per   = s + 1;
    last  = 8 * per;
    eBusy = (t >= 1) && (t <= last);
    eAbc  = eBusy ? 3'((t - 1) / per) : 3'd0;
    eTab  = 8'h00;
    for (int i = 0; i < 8; i++) if (t > (i + 1) * per) eTab[i] = tbl[i];
    checkVal($sformatf("%s_busy_t%0d", tag, t), 32'(b), 32'(eBusy));
    checkVal($sformatf("%s_abc_t%0d", tag, t), 32'(a), 32'(eAbc));
    checkVal($sformatf("%s_done_t%0d", tag, t), 32'(d), 32'(t == last + 1));
    checkVal($sformatf("%s_table_t%0d", tag, t), 32'(tab), 32'(eTab));
`ifdef TT_CHECK_EN
    checkVal($sformatf("%s_pass_t%0d", tag, t), 32'(p), 32'((t > last) && (ex == tbl)));
    checkVal($sformatf("%s_fail_t%0d", tag, t), 32'(f), 32'((t > last) && (ex != tbl)));
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkVal("rst_busy", 32'({busy1, busy3}), 32'd0);
    checkVal("rst_done", 32'({done1, done3}), 32'd0);
    checkVal("rst_abc", 32'({abc1, abc3}), 32'd0);
    checkVal("rst_table", 32'({tab1, tab3}), 32'd0);
    checkVal("rst_passfail", 32'({pass1, fail1, pass3, fail3}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full sweep on both DUTs; optional spurious start pulses while both are busy.
  task automatic runSweep(input logic [7:0] t1, input logic [7:0] t3, input bit noise,
                          input string tag);
    @(negedge clk);
    tbl1  = t1;
    tbl3  = t3;
    exp1  = $urandom_range(0, 1) ? t1 : (t1 ^ 8'(1 << $urandom_range(0, 7)));
    exp3  = $urandom_range(0, 1) ? t3 : (t3 ^ 8'(1 << $urandom_range(0, 7)));
    start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 34; t++) begin
      #1;
      checkDut({tag, "_s1"}, t, 1, busy1, abc1, done1, tab1, tbl1, pass1, fail1, exp1);
      checkDut({tag, "_s3"}, t, 3, busy3, abc3, done3, tab3, tbl3, pass3, fail3, exp3);
      @(negedge clk);
      start = (noise && t <= 15) ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(posedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    tbl1  = 8'h00;
    tbl3  = 8'h00;
    exp1  = 8'h00;
    exp3  = 8'h00;
    doReset();

    runSweep(8'h80, 8'h80, 1'b0, "and");
    runSweep(8'hE8, 8'hE8, 1'b1, "maj");
    runSweep(8'h96, 8'h96, 1'b1, "xor");
    for (int k = 0; k < 4; k++) begin
      runSweep(8'($urandom), 8'($urandom), 1'b1, $sformatf("rnd%0d", k));
    end

    // Abort mid-sweep: reset during cycle 5, no done pulse afterwards.
    @(negedge clk);
    tbl1  = 8'hFF;
    tbl3  = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 5) reset = 1'b1;
      @(posedge clk);
    end
    #1;
    checkVal("abort_busy", 32'({busy1, busy3}), 32'd0);
    checkVal("abort_abc", 32'({abc1, abc3}), 32'd0);
    checkVal("abort_table", 32'({tab1, tab3}), 32'd0);
    checkVal("abort_passfail", 32'({pass1, fail1, pass3, fail3}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seenDone = 0;
      for (int t = 0; t < 40; t++) begin
        @(posedge clk);
        #1;
        if (done1 || done3) seenDone++;
      end
      checkVal("abort_no_done", 32'(seenDone), 32'd0);
    end
    runSweep(8'h5A, 8'hC3, 1'b0, "post_abort");

    // Start held high: SETTLE=1 instance restarts in the IDLE cycle after DONE.
    @(negedge clk);
    tbl1  = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 20; t++) begin
      #1;
      if (t == 17) checkVal("hold_done17", 32'(done1), 32'd1);
      if (t == 18) checkVal("hold_idle18", 32'(busy1), 32'd0);
      if (t == 18) checkVal("hold_table18", 32'(tab1), 32'h3C);
      if (t == 19) checkVal("hold_busy19", 32'(busy1), 32'd1);
      if (t == 19) checkVal("hold_table19", 32'(tab1), 32'd0);
      if (t == 20) checkVal("hold_busy3_20", 32'(busy3), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkVal("hold_final_table", 32'(tab1), 32'h3C);
    checkVal("hold_final_idle", 32'({busy1, busy3}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
